// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-read-port register file with busy scoreboard and writeback bypass
//
// Purpose: register file for the pipelined core. Decode reads sources through
// N_READ combinational ports and marks destinations busy on issue. Writeback
// stores results and clears busy bits. Hazard flags tell decode when to hold.
//
// Ports:
//   clk_in           clock, all state updates on posedge
//   rst_n_in         synchronous active-low reset
//   rs_addr_in       read addresses, port i = [i*A_WIDTH +: A_WIDTH]
//   rd_data_out      read data, port i = [i*D_WIDTH +: D_WIDTH]
//   rs_busy_out      per-port: source still waits on an unbypassed producer
//   issue_valid_in   instruction writing issue_rd_in issues this cycle
//   issue_rd_in      destination of the issued instruction
//   issue_stall_out  destination already busy (WAW), decode must hold
//   wb_en_in         writeback enable
//   wb_rd_in         writeback destination
//   wb_data_in       writeback data
//   busy_count_out   registered popcount of busy bits
//   err_out          sticky: an issue was accepted while stalled
//   dbg_out          stored value of register DBG_REG (no bypass)

module regfile_scoreboard #(
   parameter int A_WIDTH = 5,
   parameter int D_WIDTH = 32,
   parameter int N_READ  = 2,
   parameter int DBG_REG = 10
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic [N_READ*A_WIDTH-1:0]   rs_addr_in,
   output logic [N_READ*D_WIDTH-1:0]   rd_data_out,
   output logic [N_READ-1:0]           rs_busy_out,
   input  logic                        issue_valid_in,
   input  logic [A_WIDTH-1:0]          issue_rd_in,
   output logic                        issue_stall_out,
   input  logic                        wb_en_in,
   input  logic [A_WIDTH-1:0]          wb_rd_in,
   input  logic [D_WIDTH-1:0]          wb_data_in,
   output logic [A_WIDTH:0]            busy_count_out,
   output logic                        err_out,
   output logic [D_WIDTH-1:0]          dbg_out
);

   localparam int NREG = 1 << A_WIDTH;

   logic [D_WIDTH-1:0] regs_q [NREG];
   logic [NREG-1:0]    busy_q, busy_d;
   logic [A_WIDTH:0]   count_q, count_d;
   logic               err_q, err_d;

   logic wb_write;
   logic issue_set;

   assign wb_write  = wb_en_in && (wb_rd_in != '0);
   assign issue_set = issue_valid_in && (issue_rd_in != '0);

   // A same-cycle writeback to the destination resolves the WAW, so no stall.
   assign issue_stall_out = (issue_rd_in != '0) && busy_q[issue_rd_in]
                            && !(wb_en_in && (wb_rd_in == issue_rd_in));

   // Issue is applied after writeback so that it wins on a same-cycle collision.
   always_comb begin
      busy_d = busy_q;
      if (wb_write) begin
         busy_d[wb_rd_in] = 1'b0;
      end
      if (issue_set) begin
         busy_d[issue_rd_in] = 1'b1;
      end
      count_d = '0;
      for (int r = 0; r < NREG; r++) begin
         count_d = count_d + {{A_WIDTH{1'b0}}, busy_d[r]};
      end
      err_d = err_q || (issue_valid_in && issue_stall_out);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
         busy_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (wb_write) begin
            regs_q[wb_rd_in] <= wb_data_in;
         end
         busy_q  <= busy_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_READ; gi++) begin : g_rd
         logic [A_WIDTH-1:0] addr;
         assign addr = rs_addr_in[gi*A_WIDTH +: A_WIDTH];
         always_comb begin
            rd_data_out[gi*D_WIDTH +: D_WIDTH] = regs_q[addr];
            rs_busy_out[gi]                    = busy_q[addr];
            if (addr == '0) begin
               rd_data_out[gi*D_WIDTH +: D_WIDTH] = '0;
               rs_busy_out[gi]                    = 1'b0;
            end else if (wb_en_in && (wb_rd_in == addr)) begin
               rd_data_out[gi*D_WIDTH +: D_WIDTH] = wb_data_in;
               rs_busy_out[gi]                    = 1'b0;
            end
         end
      end
   endgenerate

   assign busy_count_out = count_q;
   assign err_out        = err_q;
   assign dbg_out        = regs_q[DBG_REG];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard

module tb_regfile_scoreboard;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR*AW-1:0]  rs_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rs_busy;
   logic              issue_valid;
   logic [AW-1:0]     issue_rd;
   logic              issue_stall;
   logic              wb_en;
   logic [AW-1:0]     wb_rd;
   logic [DW-1:0]     wb_data;
   logic [AW:0]       busy_count;
   logic              err;
   logic [DW-1:0]     dbg;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   regfile_scoreboard #(.A_WIDTH(AW), .D_WIDTH(DW), .N_READ(NR), .DBG_REG(10)) dut (
      .clk_in          (clk),
      .rst_n_in        (rst_n),
      .rs_addr_in      (rs_addr),
      .rd_data_out     (rd_data),
      .rs_busy_out     (rs_busy),
      .issue_valid_in  (issue_valid),
      .issue_rd_in     (issue_rd),
      .issue_stall_out (issue_stall),
      .wb_en_in        (wb_en),
      .wb_rd_in        (wb_rd),
      .wb_data_in      (wb_data),
      .busy_count_out  (busy_count),
      .err_out         (err),
      .dbg_out         (dbg)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      issue_rd    = '0;
      wb_en       = 1'b0;
      wb_rd       = '0;
      wb_data     = '0;
   endtask

   initial begin
      rst_n   = 1'b0;
      rs_addr = '0;
      idle();
      tick();
      rst_n = 1'b1;

      // 1. random prior contents, busy bits and a raised error, then reset
      wb_en = 1'b1; wb_rd = 5'd10; wb_data = $urandom | 32'h1;
      issue_valid = 1'b1; issue_rd = 5'd12;
      tick();
      wb_rd = 5'd5; wb_data = $urandom | 32'h1;
      tick();
      idle();
      issue_valid = 1'b1; issue_rd = 5'd12;   // illegal reissue of busy x12
      tick();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      rs_addr = {5'd10, 5'd5};
      #1;
      chk("rst_rd0",   rd_data[31:0],  32'h0);
      chk("rst_rd1",   rd_data[63:32], 32'h0);
      chk("rst_count", busy_count,     6'd0);
      chk("rst_err",   err,            1'b0);
      chk("rst_dbg",   dbg,            32'h0);

      // 2. bypass on same-cycle write, then storage read
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      rs_addr = {5'd0, 5'd5};
      #1;
      chk("bypass_rd0", rd_data[31:0],  32'hDEADBEEF);
      chk("bypass_x0",  rd_data[63:32], 32'h0);
      tick();
      idle();
      #1;
      chk("stored_rd0", rd_data[31:0], 32'hDEADBEEF);

      // dbg mirrors x10 from storage only
      wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h0000CAFE;
      #1;
      chk("dbg_no_bypass", dbg, 32'h0);
      tick();
      idle();
      #1;
      chk("dbg_after_wb", dbg, 32'h0000CAFE);

      // 3. issue x7, then writeback clears it
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      idle();
      rs_addr = {5'd0, 5'd7};
      #1;
      chk("x7_busy",  rs_busy[0], 1'b1);
      chk("x7_count", busy_count, 6'd1);
      wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h12;
      #1;
      chk("x7_wb_bypass_busy", rs_busy[0],     1'b0);
      chk("x7_wb_bypass_data", rd_data[31:0],  32'h12);
      tick();
      idle();
      #1;
      chk("x7_clear_busy",  rs_busy[0],    1'b0);
      chk("x7_clear_count", busy_count,    6'd0);
      chk("x7_clear_data",  rd_data[31:0], 32'h12);

      // 4. WAW stall and sticky error
      issue_valid = 1'b1; issue_rd = 5'd3;
      tick();
      #1;
      chk("x3_stall",    issue_stall, 1'b1);
      chk("x3_err_pre",  err,         1'b0);
      tick();
      idle();
      #1;
      chk("x3_err_set",  err,         1'b1);
      chk("x3_count",    busy_count,  6'd1);
      tick();
      chk("x3_err_hold", err,         1'b1);
      issue_valid = 1'b1; issue_rd = 5'd3;
      wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
      #1;
      chk("x3_stall_wb", issue_stall, 1'b0);
      tick();
      idle();
      rs_addr = {5'd0, 5'd3};
      #1;
      chk("x3_err_unch",  err,           1'b1);
      chk("x3_busy_keep", rs_busy[0],    1'b1);
      chk("x3_data",      rd_data[31:0], 32'h33);
      wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h34;
      tick();
      idle();
      #1;
      chk("x3_count_clr", busy_count, 6'd0);

      // 5. same-cycle issue and writeback on x9; x0 is inert
      issue_valid = 1'b1; issue_rd = 5'd9;
      wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
      tick();
      idle();
      rs_addr = {5'd0, 5'd9};
      #1;
      chk("x9_data",  rd_data[31:0], 32'h55);
      chk("x9_busy",  rs_busy[0],    1'b1);
      chk("x9_count", busy_count,    6'd1);
      issue_valid = 1'b1; issue_rd = 5'd0;
      wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
      rs_addr = {5'd0, 5'd0};
      #1;
      chk("x0_bypass", rd_data[31:0], 32'h0);
      chk("x0_stall",  issue_stall,   1'b0);
      tick();
      idle();
      #1;
      chk("x0_data",  rd_data[31:0], 32'h0);
      chk("x0_busy",  rs_busy[0],    1'b0);
      chk("x0_count", busy_count,    6'd1);

      // 6. issue stream then reset mid-stream
      issue_valid = 1'b1; issue_rd = 5'd4;
      tick();
      issue_rd = 5'd6;
      tick();
      issue_rd = 5'd10;
      tick();
      #1;
      chk("stream_count", busy_count, 6'd4);
      issue_rd = 5'd11;
      wb_en = 1'b1; wb_rd = 5'd12; wb_data = 32'h77;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle();
      rs_addr = {5'd12, 5'd4};
      #1;
      chk("rst2_count", busy_count,     6'd0);
      chk("rst2_busy4", rs_busy[0],     1'b0);
      chk("rst2_x12",   rd_data[63:32], 32'h0);
      chk("rst2_dbg",   dbg,            32'h0);
      chk("rst2_err",   err,            1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
